// File: rtl/disp_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        FORCE = 2'd2
    } disp_state_e;

    localparam int DISP_DW = 8;

    // One-hot vector with bit idx set; callers slice to their requester count.
    function automatic logic [7:0] onehot8(input int idx);
        return 8'd1 << idx;
    endfunction

    // Out-of-range requester indices fall back to requester 0.
    function automatic int clamp_idx(input int idx, input int n);
        return (idx >= n) ? 0 : idx;
    endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Round-robin picker: first requester set (and not masked) after last_ptr,
// searching with wrap-around. Purely combinational.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int SELW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] last_ptr,
    input  logic [NREQ-1:0] mask,
    output logic [SELW-1:0] pick_idx,
    output logic            pick_valid
);

    logic [NREQ-1:0] cand;

    assign cand = req & ~mask;

    // Scan from farthest to nearest so the nearest hit after last_ptr wins.
    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            if (cand[(int'(last_ptr) + i) % NREQ]) begin
                pick_idx   = SELW'((int'(last_ptr) + i) % NREQ);
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Time-shares one seven-segment display between NREQ requesters with a
// round-robin dwell, plus a debug force path.
// Optional feature macro: DISP_ARB_LOCK_EN adds a lock input that freezes
// rotation while the current owner keeps requesting.
module display_arbiter
    import disp_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int DW    = DISP_DW,
    parameter  int DWELL = 50_000_000,
    localparam int SELW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] data_in,
    input  logic               force_en,
    input  logic [SELW-1:0]    force_sel,
`ifdef DISP_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [DW-1:0]      data_out,
    output logic [NREQ-1:0]    grant,
    output logic               grant_valid,
    output logic               switch_pulse
);

    localparam int            CW         = $clog2(DWELL);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    disp_state_e     state_q, state_d;
    logic [CW-1:0]   dwell_q, dwell_d;
    logic [SELW-1:0] last_ptr_q, last_ptr_d;
    logic [SELW-1:0] owner_q, owner_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [DW-1:0]   data_q, data_d;
    logic            pulse_q, pulse_d;

    logic [NREQ-1:0] pick_mask;
    logic [SELW-1:0] pick_idx;
    logic            pick_valid;
    logic [SELW-1:0] force_idx;
    logic            lock_active;

    function automatic logic [NREQ-1:0] to_grant(input logic [SELW-1:0] idx);
        logic [7:0] oh;
        oh = onehot8(int'(idx));
        return oh[NREQ-1:0];
    endfunction

`ifdef DISP_ARB_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    assign force_idx = SELW'(clamp_idx(int'(force_sel), NREQ));
    // The current owner is excluded so a dropped or expired owner is not re-picked.
    assign pick_mask = (state_q == SHOW) ? to_grant(owner_q) : '0;

    rr_pick #(
        .NREQ (NREQ),
        .SELW (SELW)
    ) u_rr_pick (
        .req        (req),
        .last_ptr   (last_ptr_q),
        .mask       (pick_mask),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    // Next-state, grant and dwell bookkeeping; pulse flags any grant change.
    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        last_ptr_d = last_ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        data_d     = (state_q == IDLE) ? '0 : data_in[int'(owner_q)*DW +: DW];

        if (force_en) begin
            state_d = FORCE;
            owner_d = force_idx;
            grant_d = to_grant(force_idx);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_d    = SHOW;
                        owner_d    = pick_idx;
                        last_ptr_d = pick_idx;
                        grant_d    = to_grant(pick_idx);
                        dwell_d    = DWELL_LAST;
                    end
                end
                SHOW: begin
                    if (!req[owner_q]) begin
                        if (pick_valid) begin
                            owner_d    = pick_idx;
                            last_ptr_d = pick_idx;
                            grant_d    = to_grant(pick_idx);
                            dwell_d    = DWELL_LAST;
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                            dwell_d = '0;
                        end
                    end else if (lock_active) begin
                        dwell_d = dwell_q;
                    end else if (dwell_q == '0) begin
                        if (pick_valid) begin
                            owner_d    = pick_idx;
                            last_ptr_d = pick_idx;
                            grant_d    = to_grant(pick_idx);
                        end
                        dwell_d = DWELL_LAST;
                    end else begin
                        dwell_d = dwell_q - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    grant_d = '0;
                    dwell_d = '0;
                end
            endcase
        end

        pulse_d = (grant_d != grant_q);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dwell_q    <= '0;
            last_ptr_q <= SELW'(NREQ - 1);
            owner_q    <= '0;
            grant_q    <= '0;
            data_q     <= '0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            last_ptr_q <= last_ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            pulse_q    <= pulse_d;
        end
    end

    assign data_out     = data_q;
    assign grant        = grant_q;
    assign grant_valid  = (grant_q != '0);
    assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (NREQ=4, DWELL=4). Every switch_pulse
// pops the next expected grant from a queue; level checks are made at
// chosen cycles from the stimulus process.
module tb_display_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int DWELL = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data_in;
    logic               force_en;
    logic [1:0]         force_sel;
    logic               lock;
    logic [DW-1:0]      data_out;
    logic [NREQ-1:0]    grant;
    logic               grant_valid;
    logic               switch_pulse;

    int total = 0;
    int bad   = 0;
    logic [NREQ-1:0] exp_q[$];

    display_arbiter #(
        .NREQ  (NREQ),
        .DW    (DW),
        .DWELL (DWELL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .data_in      (data_in),
        .force_en     (force_en),
        .force_sel    (force_sel),
`ifdef DISP_ARB_LOCK_EN
        .lock         (lock),
`endif
        .data_out     (data_out),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .switch_pulse (switch_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the next queued grant.
    always @(negedge clk) begin
        if (switch_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse_grant", int'(grant), -1);
            end else begin
                chk("pulse_grant", int'(grant), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        force_en  = 1'b0;
        force_sel = '0;
        lock      = 1'b0;
        data_in   = {8'd200, 8'd99, 8'd17, 8'd42};
        step(2);
        chk("rst_grant", int'(grant), 0);
        chk("rst_grant_valid", int'(grant_valid), 0);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_pulse", int'(switch_pulse), 0);

        // Single requester: 1-cycle grant, data one cycle later.
        rst = 1'b0;
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        step(1);                               // E1
        chk("first_grant", int'(grant), 1);
        chk("first_data_latency", int'(data_out), 0);
        step(1);                               // E2
        chk("first_data", int'(data_out), 42);

        // Round robin over 1011 with wrap.
        req = 4'b1011;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        step(2);                               // E4
        chk("rr_hold_before_expiry", int'(grant), 1);
        step(1);                               // E5
        chk("rr_to_1", int'(grant), 2);
        step(4);                               // E9
        chk("rr_to_3", int'(grant), 8);
        chk("rr_data_prev_owner", int'(data_out), 17);
        step(1);                               // E10
        chk("rr_data_owner3", int'(data_out), 200);
        step(3);                               // E13
        chk("rr_wrap_to_0", int'(grant), 1);
        step(4);                               // E17
        chk("rr_back_to_1", int'(grant), 2);

        // Lone owner keeps the display, no further pulses.
        req = 4'b0010;
        step(12);                              // E29
        chk("lone_owner_hold", int'(grant), 2);

        // Owner drops: hand over immediately, then to idle.
        req = 4'b0001;
        exp_q.push_back(4'b0001);
        step(1);                               // E30
        chk("drop_to_0", int'(grant), 1);
        step(1);                               // E31
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        step(1);                               // E32
        chk("drop_mid_dwell_to_2", int'(grant), 4);
        req = 4'b0000;
        exp_q.push_back(4'b0000);
        step(1);                               // E33
        chk("all_drop_grant", int'(grant), 0);
        chk("all_drop_valid", int'(grant_valid), 0);
        chk("all_drop_data_lag", int'(data_out), 99);
        step(1);                               // E34
        chk("idle_data_zero", int'(data_out), 0);

        // Force path.
        req       = 4'b0001;
        force_en  = 1'b1;
        force_sel = 2'd3;
        exp_q.push_back(4'b1000);
        step(1);                               // E35
        chk("force_grant", int'(grant), 8);
        step(10);                              // E45
        chk("force_hold", int'(grant), 8);
        chk("force_data", int'(data_out), 200);
        force_sel = 2'd1;
        exp_q.push_back(4'b0010);
        step(1);                               // E46
        chk("force_sel_follow", int'(grant), 2);
        force_sel = 2'd3;
        exp_q.push_back(4'b1000);
        step(9);                               // E55
        chk("force_hold_end", int'(grant), 8);
        force_en = 1'b0;
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0001);
        step(1);                               // E56
        chk("release_idle", int'(grant), 0);
        step(1);                               // E57
        chk("release_pick", int'(grant), 1);

        // Reset mid-dwell: everything cleared, no pulse.
        step(1);
        rst = 1'b1;
        step(1);
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_pulse", int'(switch_pulse), 0);
        chk("midrst_data", int'(data_out), 0);

        // Two requesters, optional lock hold, then rotation after a full dwell.
        rst = 1'b0;
        req = 4'b0011;
        exp_q.push_back(4'b0001);
        step(1);
        chk("post_rst_pick", int'(grant), 1);
`ifdef DISP_ARB_LOCK_EN
        lock = 1'b1;
        step(20);
        chk("lock_hold", int'(grant), 1);
        lock = 1'b0;
`endif
        exp_q.push_back(4'b0010);
        step(3);
        chk("rotate_not_yet", int'(grant), 1);
        step(1);
        chk("rotate_after_dwell", int'(grant), 2);

        step(2);
        chk("pending_pulses", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
